response_sender: RTL and testbench
==================================

Name: response_sender

Overview:
- Drains the memory controller's outgoing response FIFO and transmits each 65-bit response word to the host link as narrow beats under a valid/ready handshake.
- Bit 64 of a response word is the error/status flag; bits 63:0 are the data payload.
- Sits between the response FIFO's read side (read strobe, registered data out, non-empty flag) and the host-side transmit port.
- Accounts for the FIFO's write-over-read priority: in any cycle where the FIFO is being written, a read strobe is ignored.

Parameters:
- WORD_W, 64, payload width excluding the flag bit.
- BEAT_W, 32, host beat width; WORD_W must be an integer multiple of BEAT_W.
- BEATS, WORD_W/BEAT_W (derived, 2 at defaults), beats per word.
- CNT_W, 16, width of the sent-word counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- rb_nonempty  input  1  response FIFO holds at least one word.
- rb_wr_busy  input  1  response FIFO write enable for this cycle; a pop is blocked while it is high.
- rb_data  input  WORD_W+1  FIFO registered output; valid the cycle after rb_read.
- rb_read  output  1  one-cycle pop strobe to the FIFO.
- tx_valid  output  1  beat valid to the host.
- tx_ready  input  1  host accepts the beat.
- tx_data  output  BEAT_W  current beat.
- tx_flag  output  1  bit 64 of the word being sent; held on every beat of that word.
- tx_last  output  1  final beat of the word.
- busy  output  1  high in any state other than IDLE.
- sent_count  output  CNT_W  count of fully transmitted words.

Behaviour:
- Reset values: state=IDLE, tx_valid=0, tx_data=0, tx_flag=0, tx_last=0, sent_count=0, beat index=0, busy=0.
- rb_read is combinational and forced to 0 while reset=1.
- Reset mid-operation: any word in flight is discarded. A word already popped from the FIFO is lost; this is accepted behaviour.
- FSM states: IDLE, WAIT, SEND.
- IDLE:
  - rb_read = rb_nonempty & ~rb_wr_busy.
  - If rb_read=1, go to WAIT; otherwise stay in IDLE.
  - rb_read is never asserted in any other state, so the FIFO never sees two outstanding reads.
- WAIT:
  - rb_data is valid this cycle.
  - At the clock edge: capture rb_data[WORD_W-1:0] into the shift register, rb_data[WORD_W] into tx_flag, clear the beat index, and go to SEND.
- SEND:
  - tx_valid=1.
  - tx_data = word[BEAT_W*idx +: BEAT_W]; the low beat goes first.
  - tx_last = (idx == BEATS-1).
  - tx_valid & tx_ready with idx < BEATS-1: idx increments.
  - tx_valid & tx_ready with idx = BEATS-1: sent_count increments, tx_valid drops next cycle, go to IDLE.
  - Backpressure: while tx_valid=1 and tx_ready=0, tx_data, tx_flag and tx_last stay stable; there is no timeout.
  - tx_valid must never drop before the beat is accepted.
- Latency: rb_read high in cycle N, rb_data captured at the end of N+1, first beat valid in N+2.
- Throughput with tx_ready held high: one word per BEATS+2 cycles. The next rb_read occurs in the IDLE cycle after the last beat is accepted.
- Empty FIFO: stay in IDLE with no strobe.
- Write collision: rb_wr_busy=1 in IDLE suppresses rb_read; retry every cycle until rb_wr_busy=0.
- sent_count wraps from 2^CNT_W-1 to 0.
- tx_ready is a don't-care whenever tx_valid=0.
- When idle, tx_data and tx_flag hold their last values.

Test Plan:
- Single word: FIFO holds {1'b0, 64'h1122334455667788}, tx_ready=1.
  - Expect rb_read for 1 cycle, then tx_data=55667788 (tx_last=0) two cycles later, then 11223344 (tx_last=1), then sent_count=1 and busy=0.
- Backpressure: same word with tx_ready=0 for 5 cycles on beat 0.
  - tx_data holds 55667788 with tx_valid=1 for all 5 cycles; the word then completes normally.
- Back-to-back: 3 words queued, tx_ready=1.
  - rb_read pulses exactly 3 times, each 4 cycles apart; 6 beats with tx_last on beats 2, 4 and 6; sent_count=3.
- Write collision: rb_nonempty=1 with rb_wr_busy=1 for 3 cycles.
  - rb_read stays 0 for those cycles and asserts in the first cycle with rb_wr_busy=0.
- Flag and reset: word {1'b1, 64'hDEADBEEF_CAFEF00D}.
  - tx_flag=1 on both beats.
  - Assert reset during beat 1: the next cycle shows tx_valid=0, state IDLE, sent_count=0, and no tx_last is emitted.
- Counter wrap with CNT_W=2: send 5 words.
  - sent_count sequence is 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/response_sender.sv
// Drains the response FIFO and sends each 65-bit word (flag + payload) to the host as BEATS narrow beats, low beat first.
// One pop per word; the pop is suppressed while the FIFO is being written, and beats hold under tx_ready backpressure.
module response_sender #(
  parameter int WORD_W = 64,
  parameter int BEAT_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rb_nonempty,
  input  logic              rb_wr_busy,
  input  logic [WORD_W:0]   rb_data,
  output logic              rb_read,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [BEAT_W-1:0] tx_data,
  output logic              tx_flag,
  output logic              tx_last,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_count
);

  localparam int BEATS = WORD_W / BEAT_W;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, SEND} state_t;

  state_t                        state;
  logic [BEATS-1:0][BEAT_W-1:0]  word;
  logic [IDX_W-1:0]              idx;

  // Only IDLE may pop, so the FIFO never has two reads outstanding.
  assign rb_read = ~reset & (state == IDLE) & rb_nonempty & ~rb_wr_busy;
  assign busy    = (state != IDLE);
  assign tx_data = word[idx];
  assign tx_last = tx_valid & (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      word       <= '0;
      idx        <= '0;
      tx_valid   <= 1'b0;
      tx_flag    <= 1'b0;
      sent_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rb_read) state <= WAIT;
        end
        WAIT: begin
          // FIFO output is registered: the popped word is only visible now.
          word     <= rb_data[WORD_W-1:0];
          tx_flag  <= rb_data[WORD_W];
          idx      <= '0;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              tx_valid   <= 1'b0;
              sent_count <= sent_count + 1'b1;
              state      <= IDLE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_response_sender.sv
// Bench for response_sender: a FIFO model feeds words, a beat-stream model predicts every output each cycle.
module tb_response_sender;
  localparam int WORD_W = 64;
  localparam int BEAT_W = 32;
  localparam int BEATS  = WORD_W / BEAT_W;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rb_nonempty = 1'b0;
  logic              rb_wr_busy = 1'b0;
  logic [WORD_W:0]   rb_data = '0;
  logic              rb_read;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [BEAT_W-1:0] tx_data;
  logic              tx_flag;
  logic              tx_last;
  logic              busy;
  logic [CNT_W-1:0]  sent_count;

  response_sender #(.WORD_W(WORD_W), .BEAT_W(BEAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .rb_nonempty(rb_nonempty), .rb_wr_busy(rb_wr_busy),
    .rb_data(rb_data), .rb_read(rb_read), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .tx_flag(tx_flag), .tx_last(tx_last), .busy(busy),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Environment and reference model state.
  logic [WORD_W:0]   q[$];
  logic [BEAT_W+1:0] exp_beats[$];  // {last, flag, data}
  logic              pend = 1'b0;
  logic [WORD_W:0]   pend_word = '0;
  int                pops = 0, done = 0, exp_cnt = 0;
  int                cyc = 0, pop_cyc = -10;
  logic [BEAT_W-1:0] hold_data = '0;
  logic              hold_flag = 1'b0;

  task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [WORD_W:0] rand_word();
    logic [WORD_W:0] w;
    w[31:0]  = $urandom;
    w[63:32] = $urandom;
    w[64]    = 1'($urandom_range(0, 1));
    return w;
  endfunction

  // Compare DUT outputs with the model, then advance the model past the coming edge.
  task automatic check_cycle();
    logic              er, ev;
    logic [WORD_W:0]   w;
    logic [BEAT_W+1:0] fb;
    er = !reset && (pops == done) && rb_nonempty && !rb_wr_busy;
    ev = (pops != done) && (cyc >= pop_cyc + 2);
    chk("rb_read", 66'(rb_read), 66'(er));
    chk("busy", 66'(busy), 66'(pops != done));
    chk("tx_valid", 66'(tx_valid), 66'(ev));
    chk("sent_count", 66'(sent_count), 66'(exp_cnt % 4));
    if (ev) begin
      if (exp_beats.size() == 0) begin
        n_checks++; n_errors++;
        $display("FAIL beat_queue got valid beat expected none");
      end else begin
        chk("beat", 66'({tx_last, tx_flag, tx_data}), 66'(exp_beats[0]));
      end
    end else begin
      chk("idle_out", 66'({tx_last, tx_flag, tx_data}), 66'({1'b0, hold_flag, hold_data}));
    end

    if (reset) begin
      pops = 0; done = 0; exp_cnt = 0;
      exp_beats.delete();
      hold_data = '0; hold_flag = 1'b0;
      pend = 1'b0;
    end else begin
      if (rb_read && !rb_wr_busy && q.size() > 0) begin
        w = q.pop_front();
        pend = 1'b1; pend_word = w;
        pops++; pop_cyc = cyc;
        for (int b = 0; b < BEATS; b++)
          exp_beats.push_back({b == BEATS - 1, w[WORD_W], w[BEAT_W*b +: BEAT_W]});
      end
      if (ev && tx_ready && exp_beats.size() > 0) begin
        fb = exp_beats.pop_front();
        hold_data = fb[BEAT_W-1:0];
        hold_flag = fb[BEAT_W];
        if (fb[BEAT_W+1]) begin
          done++;
          exp_cnt = (exp_cnt + 1) % 4;
        end
      end
    end
    if (rb_wr_busy) q.push_back(rand_word());
    cyc++;
  endtask

  // One clock: FIFO side updates after the edge, inputs applied, checks on the falling edge.
  task automatic cycle(input logic rst, input logic rdy, input logic wb);
    @(posedge clk);
    #1;
    rb_nonempty = (q.size() != 0);
    rb_data     = pend ? pend_word : rand_word();
    pend        = 1'b0;
    reset       = rst;
    tx_ready    = rdy;
    rb_wr_busy  = wb;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (q.size() == 0 && !busy && !rb_read && !rb_nonempty) return;
    end
    n_checks++; n_errors++;
    $display("FAIL drain_timeout got busy=%0b queued=%0d expected idle", busy, q.size());
  endtask

  initial begin
    int reads[$];
    int nbeats, vals[$], prev;
    logic [5:0] lastmask;
    int exp_seq[5];
    exp_seq = '{1, 2, 3, 0, 1};

    // Reset holds the strobe low even with a word waiting.
    q.push_back({1'b0, 64'h1122334455667788});
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("rst_rb_read", 66'(rb_read), 66'(0));
    chk("rst_tx_valid", 66'(tx_valid), 66'(0));
    chk("rst_busy", 66'(busy), 66'(0));
    chk("rst_count", 66'(sent_count), 66'(0));
    chk("rst_outs", 66'({tx_last, tx_flag, tx_data}), 66'(0));

    // Single word, host always ready.
    cycle(1'b0, 1'b1, 1'b0); chk("t1_read", 66'(rb_read), 66'(1));
    cycle(1'b0, 1'b1, 1'b0); chk("t1_wait_valid", 66'(tx_valid), 66'(0));
    cycle(1'b0, 1'b1, 1'b0);
    chk("t1_beat0", 66'({tx_valid, tx_last, tx_data}), 66'({1'b1, 1'b0, 32'h55667788}));
    cycle(1'b0, 1'b1, 1'b0);
    chk("t1_beat1", 66'({tx_valid, tx_last, tx_data}), 66'({1'b1, 1'b1, 32'h11223344}));
    cycle(1'b0, 1'b1, 1'b0);
    chk("t1_done", 66'({busy, tx_valid, sent_count}), 66'({1'b0, 1'b0, 2'd1}));

    // Backpressure on beat 0 for 5 cycles.
    q.push_back({1'b0, 64'h1122334455667788});
    cycle(1'b0, 1'b0, 1'b0); chk("t2_read", 66'(rb_read), 66'(1));
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      chk("t2_stall", 66'({tx_valid, tx_last, tx_data}), 66'({1'b1, 1'b0, 32'h55667788}));
    end
    cycle(1'b0, 1'b1, 1'b0);
    chk("t2_beat0", 66'({tx_valid, tx_data}), 66'({1'b1, 32'h55667788}));
    cycle(1'b0, 1'b1, 1'b0);
    chk("t2_beat1", 66'({tx_valid, tx_last, tx_data}), 66'({1'b1, 1'b1, 32'h11223344}));
    cycle(1'b0, 1'b1, 1'b0);
    chk("t2_count", 66'(sent_count), 66'(2));

    // Three words back to back.
    for (int i = 0; i < 3; i++) q.push_back(rand_word());
    nbeats = 0; lastmask = '0;
    for (int i = 0; i < 14; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (rb_read) reads.push_back(i);
      if (tx_valid) begin
        if (tx_last && nbeats < 6) lastmask[nbeats] = 1'b1;
        nbeats++;
      end
    end
    chk("t3_reads", 66'(reads.size()), 66'(3));
    if (reads.size() == 3) begin
      chk("t3_gap1", 66'(reads[1] - reads[0]), 66'(4));
      chk("t3_gap2", 66'(reads[2] - reads[1]), 66'(4));
    end
    chk("t3_beats", 66'(nbeats), 66'(6));
    chk("t3_lastmask", 66'(lastmask), 66'(6'b101010));
    chk("t3_count", 66'(sent_count), 66'(1));

    // Write collision blocks the pop for three cycles.
    q.push_back(rand_word());
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      chk("t4_blocked", 66'(rb_read), 66'(0));
    end
    cycle(1'b0, 1'b1, 1'b0); chk("t4_read", 66'(rb_read), 66'(1));
    drain();

    // Flag word, reset during beat 1.
    q.push_back({1'b1, 64'hDEADBEEFCAFEF00D});
    cycle(1'b0, 1'b1, 1'b0); chk("t5_read", 66'(rb_read), 66'(1));
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("t5_beat0", 66'({tx_flag, tx_last, tx_data}), 66'({1'b1, 1'b0, 32'hCAFEF00D}));
    cycle(1'b1, 1'b0, 1'b0);
    chk("t5_beat1", 66'({tx_flag, tx_data}), 66'({1'b1, 32'hDEADBEEF}));
    cycle(1'b0, 1'b1, 1'b0);
    chk("t5_after_rst", 66'({tx_valid, busy, tx_last, sent_count}), 66'(0));

    // Counter wrap with a 2-bit counter.
    for (int i = 0; i < 5; i++) q.push_back(rand_word());
    prev = int'(sent_count);
    for (int i = 0; i < 30; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      if (int'(sent_count) != prev) begin
        vals.push_back(int'(sent_count));
        prev = int'(sent_count);
      end
    end
    chk("t6_nvals", 66'(vals.size()), 66'(5));
    for (int i = 0; i < 5; i++)
      if (i < vals.size()) chk("t6_seq", 66'(vals[i]), 66'(exp_seq[i]));

    // Randomized traffic, backpressure, collisions and occasional resets.
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 5) == 0));
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
